regfile_dump_uart_tx: RTL and testbench

- Debug reader for the CPU register-file probe port. On a start request it drives the probe address `RegAddr` to each register in turn and samples `RegData`.
- Each 32-bit value is serialised over a UART transmit line as 4 bytes, MSB first. Standard 8N1 framing, LSB-first bit order.
- Sits beside Mips_Pip_CPU on the FPGA top level. It replaces the simulation-only probing of `RegAddr`/`RegData` with a hardware path to a host PC.

---
 rtl/regfile_dump_uart_tx_if.sv | 28 ++
 rtl/regfile_dump_uart_tx.sv | 233 +++++++++++++++++++++++
 tb/tb_regfile_dump_uart_tx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_uart_tx_if.sv
// Probe/UART bundle for regfile_dump_uart_tx: start handshake, register-file probe
// address/data, serial line and status flags.
interface regfile_dump_uart_tx_if;
    logic        start;
    logic [4:0]  RegAddr;
    logic [31:0] RegData;
    logic        tx;
    logic        busy;
    logic        done;

    modport slave (
        input  start,
        input  RegData,
        output RegAddr,
        output tx,
        output busy,
        output done
    );

    modport master (
        output start,
        output RegData,
        input  RegAddr,
        input  tx,
        input  busy,
        input  done
    );
endinterface

// File: rtl/regfile_dump_uart_tx.sv
// Walks the CPU register-file probe port and streams each 32-bit register MSB byte first
// as 8N1 UART frames. Define REGDUMP_CHECKSUM_EN to append an XOR checksum frame.
module regfile_dump_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_REGS     = 32,
    parameter int READ_LAT     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_dump_uart_tx_if.slave  bus
);

    localparam int             BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]  BAUD_ONE  = BW'(1);
    localparam logic [1:0]     LAT_LAST  = 2'((READ_LAT > 0) ? (READ_LAT - 1) : 0);
    localparam logic [4:0]     ADDR_LAST = 5'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETADDR   = 3'd1,
        S_CAPTURE   = 3'd2,
        S_START_BIT = 3'd3,
        S_DATA_BITS = 3'd4,
        S_STOP_BIT  = 3'd5,
        S_DONE      = 3'd6
`ifdef REGDUMP_CHECKSUM_EN
        , S_CHKSUM  = 3'd7
`endif
    } state_t;

    // With zero read latency the address wait is skipped entirely.
    localparam state_t S_FETCH = (READ_LAT > 0) ? S_SETADDR : S_CAPTURE;

    state_t         r_state, w_state;
    logic [BW-1:0]  r_baud,  w_baud;
    logic [1:0]     r_lat,   w_lat;
    logic [3:0]     r_bit,   w_bit;
    logic [1:0]     r_byte,  w_byte;
    logic [31:0]    r_word,  w_word;
    logic [4:0]     r_addr,  w_addr;
    logic           r_tx,    w_tx;
    logic           r_busy,  w_busy;
    logic           r_done,  w_done;
    logic [7:0]     w_tx_byte;
    logic           w_baud_end;
`ifdef REGDUMP_CHECKSUM_EN
    logic [7:0]     r_xor,   w_xor;
`endif

    assign w_baud_end  = (r_baud == BAUD_LAST);
    assign bus.RegAddr = r_addr;
    assign bus.tx      = r_tx;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

    // Next-state, counter and registered-output computation.
    always_comb begin
        w_state   = r_state;
        w_baud    = r_baud;
        w_lat     = r_lat;
        w_bit     = r_bit;
        w_byte    = r_byte;
        w_word    = r_word;
        w_addr    = r_addr;
        w_tx      = 1'b1;
        w_tx_byte = 8'h00;
`ifdef REGDUMP_CHECKSUM_EN
        w_xor     = r_xor;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state = S_FETCH;
                    w_addr  = 5'd0;
                    w_lat   = 2'd0;
                    w_baud  = '0;
`ifdef REGDUMP_CHECKSUM_EN
                    w_xor   = 8'h00;
`endif
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_SETADDR: begin
                if (r_lat == LAT_LAST) begin
                    w_state = S_CAPTURE;
                    w_lat   = 2'd0;
                end else begin
                    w_lat   = r_lat + 2'd1;
                end
            end
            S_CAPTURE: begin
                w_word  = bus.RegData;
                w_byte  = 2'd0;
                w_baud  = '0;
                w_state = S_START_BIT;
`ifdef REGDUMP_CHECKSUM_EN
                w_xor   = r_xor ^ bus.RegData[31:24] ^ bus.RegData[23:16]
                                ^ bus.RegData[15:8]  ^ bus.RegData[7:0];
`endif
            end
            S_START_BIT: begin
                if (w_baud_end) begin
                    w_baud  = '0;
                    w_bit   = 4'd0;
                    w_state = S_DATA_BITS;
                end else begin
                    w_baud  = r_baud + BAUD_ONE;
                end
            end
            S_DATA_BITS: begin
                if (w_baud_end) begin
                    w_baud = '0;
                    if (r_bit == 4'd7) begin
                        w_state = S_STOP_BIT;
                    end else begin
                        w_bit = r_bit + 4'd1;
                    end
                end else begin
                    w_baud = r_baud + BAUD_ONE;
                end
            end
            S_STOP_BIT: begin
                if (w_baud_end) begin
                    w_baud = '0;
                    if (r_byte != 2'd3) begin
                        w_byte  = r_byte + 2'd1;
                        w_word  = {r_word[23:0], 8'h00};
                        w_state = S_START_BIT;
                    end else if (r_addr < ADDR_LAST) begin
                        w_addr  = r_addr + 5'd1;
                        w_lat   = 2'd0;
                        w_state = S_FETCH;
                    end else begin
`ifdef REGDUMP_CHECKSUM_EN
                        w_bit   = 4'd0;
                        w_state = S_CHKSUM;
`else
                        w_state = S_DONE;
`endif
                    end
                end else begin
                    w_baud = r_baud + BAUD_ONE;
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            // Whole checksum frame in one state: bit 0 is start, 1..8 data, 9 stop.
            S_CHKSUM: begin
                if (w_baud_end) begin
                    w_baud = '0;
                    if (r_bit == 4'd9) begin
                        w_state = S_DONE;
                    end else begin
                        w_bit = r_bit + 4'd1;
                    end
                end else begin
                    w_baud = r_baud + BAUD_ONE;
                end
            end
`endif
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
        w_done = (w_state == S_DONE);

        // The line level is derived from the upcoming state so tx stays registered.
        case (w_state)
            S_START_BIT: begin
                w_tx = 1'b0;
            end
            S_DATA_BITS: begin
                w_tx_byte = w_word[31:24];
                w_tx      = w_tx_byte[w_bit[2:0]];
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CHKSUM: begin
                if (w_bit == 4'd0) begin
                    w_tx = 1'b0;
                end else if (w_bit == 4'd9) begin
                    w_tx = 1'b1;
                end else begin
                    w_tx_byte = w_xor;
                    w_tx      = w_tx_byte[3'(w_bit - 4'd1)];
                end
            end
`endif
            default: begin
                w_tx = 1'b1;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_lat   <= 2'd0;
            r_bit   <= 4'd0;
            r_byte  <= 2'd0;
            r_word  <= 32'h0000_0000;
            r_addr  <= 5'd0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            r_xor   <= 8'h00;
`endif
        end else begin
            r_state <= w_state;
            r_baud  <= w_baud;
            r_lat   <= w_lat;
            r_bit   <= w_bit;
            r_byte  <= w_byte;
            r_word  <= w_word;
            r_addr  <= w_addr;
            r_tx    <= w_tx;
            r_busy  <= w_busy;
            r_done  <= w_done;
`ifdef REGDUMP_CHECKSUM_EN
            r_xor   <= w_xor;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_dump_uart_tx.sv
// Directed/randomised bench for regfile_dump_uart_tx: expected tx waveform and bytes are
// built from the framing rules and compared against the recorded serial line.
module tb_regfile_dump_uart_tx;

    localparam int CPB   = 4;
    localparam int NR    = 2;
    localparam int RL    = 1;
    localparam int FRAME = 10 * CPB;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int CHK   = 1;
`else
    localparam int CHK   = 0;
`endif
    localparam int DUMP_LEN = NR * (4 * FRAME + RL + 1) + 1 + CHK * FRAME;
    localparam int REC_LEN  = DUMP_LEN + 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    regfile_dump_uart_tx_if bus ();

    regfile_dump_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .NUM_REGS     (NR),
        .READ_LAT     (RL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Register-file model: data valid one cycle after the probe address changes.
    logic [31:0] regs [32];
    always @(posedge clk) bus.RegData <= regs[bus.RegAddr];

    int checks = 0;
    int fails  = 0;

    bit         exp_w [$];
    logic [7:0] exp_b [$];
    logic [7:0] got_b [$];
    bit         got_w [REC_LEN];
    logic [31:0] snap [NR];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] b);
        repeat (CPB) exp_w.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (CPB) exp_w.push_back(b[i]);
        repeat (CPB) exp_w.push_back(1'b1);
    endtask

    // Expected line: per register READ_LAT+1 idle cycles then four frames MSB byte first.
    task automatic build_expected();
        logic [7:0] x;
        logic [7:0] b;
        exp_w.delete();
        exp_b.delete();
        x = 8'h00;
        for (int r = 0; r < NR; r++) begin
            repeat (RL + 1) exp_w.push_back(1'b1);
            for (int k = 0; k < 4; k++) begin
                b = 8'(snap[r] >> (24 - 8 * k));
                exp_b.push_back(b);
                x = x ^ b;
                push_frame(b);
            end
        end
        if (CHK != 0) begin
            exp_b.push_back(x);
            push_frame(x);
        end
        while (exp_w.size() < REC_LEN) exp_w.push_back(1'b1);
    endtask

    task automatic decode();
        int i;
        logic [7:0] b;
        got_b.delete();
        i = 0;
        while (i + 9 * CPB + CPB / 2 < REC_LEN) begin
            if (got_w[i] == 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = got_w[i + CPB * (k + 1) + CPB / 2];
                got_b.push_back(b);
                i = i + 9 * CPB + CPB / 2;
            end else begin
                i++;
            end
        end
    endtask

    task automatic run_dump(input string tag, input int retrig_at, input int mutate_at);
        int ndone;
        int first_done;
        int nmis;
        for (int r = 0; r < NR; r++) snap[r] = regs[r];
        build_expected();
        ndone = 0;
        first_done = -1;
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check({tag, "_busy_on"}, 32'(bus.busy), 32'd1);
        for (int j = 0; j < REC_LEN; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
            end
            got_w[j] = bus.tx;
            if (bus.done === 1'b1) begin
                ndone++;
                if (first_done < 0) first_done = j;
            end
            bus.start = (j == retrig_at);
            if (j == mutate_at) regs[0] = $urandom;
        end
        bus.start = 1'b0;
        nmis = 0;
        for (int j = 0; j < REC_LEN; j++) if (got_w[j] !== exp_w[j]) nmis++;
        check({tag, "_wave_mismatches"}, 32'(nmis), 32'd0);
        check({tag, "_done_count"}, 32'(ndone), 32'd1);
        check({tag, "_done_cycle"}, 32'(first_done), 32'(DUMP_LEN - 1));
        check({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
        check({tag, "_addr_hold"}, 32'(bus.RegAddr), 32'(NR - 1));
        decode();
        check({tag, "_byte_count"}, 32'(got_b.size()), 32'(exp_b.size()));
        for (int k = 0; k < exp_b.size() && k < got_b.size(); k++)
            check($sformatf("%s_byte%0d", tag, k), 32'(got_b[k]), 32'(exp_b[k]));
    endtask

    initial begin
        int run;
        int ndone;
        int nlow;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        bus.start = 1'b1;
        reset = 1'b0;

        // Reset held with start high.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("rst_tx", 32'(bus.tx), 32'd1);
            check("rst_busy", 32'(bus.busy), 32'd0);
            check("rst_done", 32'(bus.done), 32'd0);
            check("rst_addr", 32'(bus.RegAddr), 32'd0);
        end
        bus.start = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rel_tx", 32'(bus.tx), 32'd1);
        check("rel_busy", 32'(bus.busy), 32'd0);
        check("rel_addr", 32'(bus.RegAddr), 32'd0);

        // Single dump with the reference values, then a retriggered identical repeat.
        regs[0] = 32'h0000_000A;
        regs[1] = 32'h1234_5678;
        run_dump("single", -1, -1);
        run_dump("retrig", 200, -1);

        // Alternating bit pattern: start bits must be exactly CPB cycles low.
        regs[0] = 32'hA5A5_A5A5;
        regs[1] = 32'hA5A5_A5A5;
        run_dump("a5", -1, -1);
        run = 0;
        while (RL + 1 + run < REC_LEN && got_w[RL + 1 + run] == 1'b0) run++;
        check("a5_start_len", 32'(run), 32'(CPB));

        // Random contents; register 0 changes while its bytes are on the line.
        for (int t = 0; t < 3; t++) begin
            regs[0] = $urandom;
            regs[1] = $urandom;
            run_dump($sformatf("rand%0d", t), -1, 10);
        end

        // Reset during the data bits of byte 2 of register 0.
        regs[0] = $urandom;
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (RL + 1 + 2 * FRAME + CPB + 8) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_tx", 32'(bus.tx), 32'd1);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_addr", 32'(bus.RegAddr), 32'd0);
        reset = 1'b1;
        ndone = 0;
        nlow = 0;
        for (int c = 0; c < DUMP_LEN; c++) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0) ndone++;
            if (bus.tx !== 1'b1) nlow++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        check("midrst_line_idle", 32'(nlow), 32'd0);
        run_dump("after_rst", -1, -1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
